// File: rtl/kv_resp_joiner.sv
// Joins a lookup-meta stream with a RAM read-data stream into a response:
// one header beat, followed by one value beat on a hit with nonzero length.
module kv_resp_joiner #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_axis_meta_valid,
    output logic             s_axis_meta_ready,
    input  logic [63:0]      s_axis_meta_key,
    input  logic             s_axis_meta_hit,
    input  logic             s_axis_ram_valid,
    output logic             s_axis_ram_ready,
    input  logic [15:0]      s_axis_ram_lenth,
    input  logic [511:0]     s_axis_ram_data,
    output logic             m_axis_resp_valid,
    input  logic             m_axis_resp_ready,
    output logic [511:0]     m_axis_resp_data,
    output logic [63:0]      m_axis_resp_keep,
    output logic             m_axis_resp_last,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             len_err
);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t         state, state_nxt;
    logic [63:0]    key_q;
    logic           hit_q;
    logic [15:0]    len_q;
    logic [511:0]   payload_q;
    logic           join_ok;
    logic           hdr_last;
    logic [63:0]    data_keep;

    // Gating with rst_n keeps both upstream readies low while reset is held.
    assign join_ok  = (state == IDLE) && s_axis_meta_valid && s_axis_ram_valid && rst_n;
    assign len_err  = join_ok && s_axis_meta_hit && (s_axis_ram_lenth > 16'd64);
    assign hdr_last = !hit_q || (len_q == 16'd0);
    assign data_keep = (len_q >= 16'd64) ? '1 : ((64'd1 << len_q[5:0]) - 64'd1);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the captured transaction is not reset; outputs are forced to zero
    // in IDLE, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (join_ok) begin
            key_q     <= s_axis_meta_key;
            hit_q     <= s_axis_meta_hit;
            len_q     <= s_axis_ram_lenth;
            payload_q <= s_axis_ram_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == HDR && m_axis_resp_ready) begin
            if (!hit_q) begin
                miss_cnt <= miss_cnt + 1'b1;
            end else if (hdr_last) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
        end else if (state == DATA && m_axis_resp_ready) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can infer a latch.
    always_comb begin
        state_nxt         = state;
        s_axis_meta_ready = 1'b0;
        s_axis_ram_ready  = 1'b0;
        m_axis_resp_valid = 1'b0;
        m_axis_resp_data  = '0;
        m_axis_resp_keep  = '0;
        m_axis_resp_last  = 1'b0;
        case (state)
            IDLE: begin
                if (join_ok) begin
                    s_axis_meta_ready = 1'b1;
                    s_axis_ram_ready  = 1'b1;
                    state_nxt         = HDR;
                end
            end
            HDR: begin
                m_axis_resp_valid = 1'b1;
                m_axis_resp_data  = {431'd0, hit_q, (hit_q ? len_q : 16'd0), key_q};
                m_axis_resp_keep  = 64'h7FF;
                m_axis_resp_last  = hdr_last;
                if (m_axis_resp_ready) begin
                    state_nxt = hdr_last ? IDLE : DATA;
                end
            end
            DATA: begin
                m_axis_resp_valid = 1'b1;
                m_axis_resp_data  = payload_q;
                m_axis_resp_keep  = data_keep;
                m_axis_resp_last  = 1'b1;
                if (m_axis_resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_kv_resp_joiner.sv
// Directed bench for kv_resp_joiner: a vector table of single responses plus
// hand-written skew, backpressure and mid-response reset sequences.
module tb_kv_resp_joiner;

    logic         clk;
    logic         rst_n;
    logic         meta_valid, meta_ready, meta_hit;
    logic [63:0]  meta_key;
    logic         ram_valid, ram_ready;
    logic [15:0]  ram_lenth;
    logic [511:0] ram_data;
    logic         resp_valid, resp_ready, resp_last;
    logic [511:0] resp_data;
    logic [63:0]  resp_keep;
    logic [31:0]  hit_cnt, miss_cnt;
    logic         len_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_hit   = 0;
    int exp_miss  = 0;

    kv_resp_joiner #(.CNT_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_meta_valid (meta_valid),
        .s_axis_meta_ready (meta_ready),
        .s_axis_meta_key   (meta_key),
        .s_axis_meta_hit   (meta_hit),
        .s_axis_ram_valid  (ram_valid),
        .s_axis_ram_ready  (ram_ready),
        .s_axis_ram_lenth  (ram_lenth),
        .s_axis_ram_data   (ram_data),
        .m_axis_resp_valid (resp_valid),
        .m_axis_resp_ready (resp_ready),
        .m_axis_resp_data  (resp_data),
        .m_axis_resp_keep  (resp_keep),
        .m_axis_resp_last  (resp_last),
        .hit_cnt           (hit_cnt),
        .miss_cnt          (miss_cnt),
        .len_err           (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] key;
        logic        hit;
        logic [15:0] len;
        logic [15:0] exp_len_f;
        logic        exp_last;
        logic [63:0] exp_keep;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] hdr(input logic [63:0] key, input logic hit, input logic [15:0] len_f);
        return {431'd0, hit, len_f, key};
    endfunction

    task automatic check_idle_counts(input string tag);
        check({tag, " idle valid"}, 512'(resp_valid), 512'(0));
        check({tag, " hit_cnt"},    512'(hit_cnt),    512'(exp_hit));
        check({tag, " miss_cnt"},   512'(miss_cnt),   512'(exp_miss));
    endtask

    // One full response with ready held high; expected values come from the table.
    task automatic run_txn(input vec_t v, input string tag);
        @(negedge clk);
        meta_valid = 1'b1; ram_valid = 1'b1; meta_key = v.key; meta_hit = v.hit;
        ram_lenth = v.len; ram_data = {8{v.key}}; resp_ready = 1'b1;
        #1;
        check({tag, " meta_ready"}, 512'(meta_ready), 512'(1));
        check({tag, " ram_ready"},  512'(ram_ready),  512'(1));
        check({tag, " len_err"},    512'(len_err),    512'(v.exp_err));
        @(negedge clk);
        meta_valid = 1'b0; ram_valid = 1'b0;
        #1;
        check({tag, " hdr valid"}, 512'(resp_valid), 512'(1));
        check({tag, " hdr data"},  resp_data, hdr(v.key, v.hit, v.exp_len_f));
        check({tag, " hdr keep"},  512'(resp_keep), 512'(64'h7FF));
        check({tag, " hdr last"},  512'(resp_last), 512'(v.exp_last));
        check({tag, " hdr len_err"}, 512'(len_err), 512'(0));
        if (!v.exp_last) begin
            @(negedge clk);
            #1;
            check({tag, " dat valid"}, 512'(resp_valid), 512'(1));
            check({tag, " dat data"},  resp_data, {8{v.key}});
            check({tag, " dat keep"},  512'(resp_keep), 512'(v.exp_keep));
            check({tag, " dat last"},  512'(resp_last), 512'(1));
        end
        if (v.hit) exp_hit++; else exp_miss++;
        @(negedge clk);
        #1;
        check_idle_counts(tag);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{64'hA5A5_0000_0000_0001, 1'b1, 16'd16,  16'd16,  1'b0, 64'h0000_0000_0000_FFFF, 1'b0};
        vecs[1] = '{64'h0000_0000_0000_0002, 1'b0, 16'd40,  16'd0,   1'b1, 64'h0,                   1'b0};
        vecs[2] = '{64'h0000_0000_0000_0003, 1'b1, 16'd100, 16'd100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[3] = '{64'h0000_0000_0000_0004, 1'b1, 16'd0,   16'd0,   1'b1, 64'h0,                   1'b0};
        vecs[4] = '{64'h0000_0000_0000_0005, 1'b1, 16'd64,  16'd64,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[5] = '{64'h0000_0000_0000_0006, 1'b1, 16'd1,   16'd1,   1'b0, 64'h0000_0000_0000_0001, 1'b0};
        vecs[6] = '{64'h0000_0000_0000_0007, 1'b0, 16'd0,   16'd0,   1'b1, 64'h0,                   1'b0};
        vecs[7] = '{64'h0000_0000_0000_0008, 1'b1, 16'd65,  16'd65,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

        rst_n = 1'b0; meta_valid = 1'b0; ram_valid = 1'b0; meta_key = '0; meta_hit = 1'b0;
        ram_lenth = '0; ram_data = '0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        meta_valid = 1'b1; ram_valid = 1'b1;
        #1;
        check("rst valid",      512'(resp_valid), 512'(0));
        check("rst meta_ready", 512'(meta_ready), 512'(0));
        check("rst ram_ready",  512'(ram_ready),  512'(0));
        check("rst data",       resp_data, 512'(0));
        check("rst hit_cnt",    512'(hit_cnt), 512'(0));
        meta_valid = 1'b0; ram_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Meta arrives 5 cycles ahead of RAM data.
        @(negedge clk);
        meta_valid = 1'b1; meta_key = 64'hB; meta_hit = 1'b0; ram_lenth = 16'd5;
        ram_data = {8{64'hB}}; resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("skew%0d meta_ready", i), 512'(meta_ready), 512'(0));
            check($sformatf("skew%0d ram_ready", i),  512'(ram_ready),  512'(0));
            check($sformatf("skew%0d valid", i),      512'(resp_valid), 512'(0));
            @(negedge clk);
        end
        ram_valid = 1'b1;
        #1;
        check("skew join meta_ready", 512'(meta_ready), 512'(1));
        check("skew join ram_ready",  512'(ram_ready),  512'(1));
        @(negedge clk);
        meta_valid = 1'b0; ram_valid = 1'b0;
        #1;
        check("skew hdr data", resp_data, hdr(64'hB, 1'b0, 16'd0));
        check("skew hdr last", 512'(resp_last), 512'(1));
        exp_miss++;
        @(negedge clk);
        #1;
        check_idle_counts("skew");

        // Backpressure: 4 stalled cycles on the header, 3 on the data beat.
        @(negedge clk);
        meta_valid = 1'b1; ram_valid = 1'b1; meta_key = 64'hC; meta_hit = 1'b1;
        ram_lenth = 16'd16; ram_data = {8{64'hC}}; resp_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp hdr%0d valid", i), 512'(resp_valid), 512'(1));
            check($sformatf("bp hdr%0d data", i),  resp_data, hdr(64'hC, 1'b1, 16'd16));
            check($sformatf("bp hdr%0d last", i),  512'(resp_last), 512'(0));
            check($sformatf("bp hdr%0d up_ready", i), 512'({meta_ready, ram_ready}), 512'(0));
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp dat%0d valid", i), 512'(resp_valid), 512'(1));
            check($sformatf("bp dat%0d data", i),  resp_data, {8{64'hC}});
            check($sformatf("bp dat%0d keep", i),  512'(resp_keep), 512'(64'hFFFF));
            check($sformatf("bp dat%0d up_ready", i), 512'({meta_ready, ram_ready}), 512'(0));
            @(negedge clk);
        end
        meta_valid = 1'b0; ram_valid = 1'b0; resp_ready = 1'b1;
        exp_hit++;
        @(negedge clk);
        #1;
        check_idle_counts("bp");

        // Reset while the data beat is stalled.
        meta_valid = 1'b1; ram_valid = 1'b1; meta_key = 64'hD; meta_hit = 1'b1;
        ram_lenth = 16'd32; ram_data = {8{64'hD}}; resp_ready = 1'b0;
        @(negedge clk);
        meta_valid = 1'b0; ram_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        check("rstmid in data", 512'(resp_valid & resp_last), 512'(1));
        @(negedge clk);
        rst_n = 1'b0; meta_valid = 1'b1; ram_valid = 1'b1; ram_lenth = 16'd100;
        #1;
        check("rstmid valid",    512'(resp_valid), 512'(0));
        check("rstmid data",     resp_data, 512'(0));
        check("rstmid keep_last", 512'({resp_keep, resp_last}), 512'(0));
        check("rstmid up_ready", 512'({meta_ready, ram_ready}), 512'(0));
        check("rstmid len_err",  512'(len_err), 512'(0));
        exp_hit = 0; exp_miss = 0;
        check_idle_counts("rstmid");
        meta_valid = 1'b0; ram_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_idle_counts("post rst");
        run_txn(vecs[0], "post rst txn");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
